vram_blit: RTL
==============

Name: vram_blit

Overview:
- Bus initiator that drives the VRAM-side port (v_stb/v_we/v_addra/v_dina, v_douta/v_ACK) of the SRAM arbiter/controller.
- Executes rectangle commands from the CPU-side control logic:
  - FILL: write a constant 16-bit pixel.
  - COPY: read a source rectangle, write it to a destination rectangle.
- Frees the CPU from per-pixel VRAM traffic. It is the only master on the v_* port.

Parameters:
- ADDR_W, 20, VRAM word-address width; all address arithmetic is modulo 2^ADDR_W.
- DIM_W, 10, width of the rectangle width/height fields.
- ROW_PITCH, 640, address increment between rectangle rows.
- TIMEOUT, 255, max cycles v_stb may stay high without an accepted transfer.

Ports:
- clk_50mhz  in  1  system clock, same clock as the SRAM controller.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle, command accepted when cmd_valid&cmd_ready.
- cmd_op  in  1  0=FILL, 1=COPY.
- cmd_src  in  ADDR_W  COPY source top-left address.
- cmd_dst  in  ADDR_W  destination top-left address.
- cmd_w  in  DIM_W  pixels per row.
- cmd_h  in  DIM_W  rows.
- cmd_color  in  16  FILL pixel value (COPY: see optional feature).
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command end.
- err  out  1  one-cycle pulse coincident with done when aborted by timeout.
- v_stb  out  1  bus request.
- v_we  out  1  1=write.
- v_addra  out  ADDR_W  bus address.
- v_dina  out  48  write data; {32'b0, pixel}.
- v_douta  in  48  read data; pixel in [15:0].
- v_ACK  in  1  controller ready.

Behaviour:
- Reset (async, rst_n=0): v_stb=0, v_we=0, v_addra=0, v_dina=0, busy=0, done=0, err=0, cmd_ready=1, state IDLE. Reset mid-transfer drops v_stb immediately; no completion pulse.
- cmd_ready = (state==IDLE). Command fields are latched on acceptance and ignored afterwards.
- Bus handshake, per transaction:
  - v_stb, v_we, v_addra and v_dina are registered and held stable while v_stb=1.
  - v_ACK is ignored in the first cycle v_stb is high. The controller's write sequencer reports ready spuriously in that cycle.
  - The transfer is accepted on the first later rising edge with v_ACK=1.
  - v_stb is low for at least one cycle after every accepted transfer, so the controller's sequencer returns to its start state.
  - Minimum transaction = 3 cycles (2 stb + 1 gap).
  - Reads: v_douta[15:0] is captured on the accept edge.
- States:
  - IDLE -> (accept, w!=0, h!=0) RD if COPY, else WR.
  - IDLE -> (accept, w==0 or h==0) DONE. No bus cycles occur.
  - RD: stb, we=0, addr=src_ptr. On accept, latch pixel -> GAP_R.
  - GAP_R -> WR.
  - WR: stb, we=1, addr=dst_ptr, data=pixel (COPY) or cmd_color (FILL). On accept -> GAP_W.
  - GAP_W -> advance.
    - x<w-1: x+1; ptrs +1.
    - x==w-1 and y<h-1: x=0, y+1, ptrs = row_base + ROW_PITCH.
    - Otherwise -> DONE.
    - Next state after advancing is RD for COPY, WR for FILL.
  - DONE: done=1 one cycle, busy=0 next cycle -> IDLE.
- Pointers: separate src/dst row bases plus offset x. All sums wrap at 2^ADDR_W; no error on wrap.
- Timeout: a counter runs while v_stb=1 and clears per transaction. On reaching TIMEOUT without accept: drop v_stb, pulse done and err together, go to IDLE. Partial writes are not undone.
- v_ACK held low (controller in init) simply stalls until timeout.
- busy=1 from the cycle after acceptance through the done cycle.
- Pixel write order: row-major, left-to-right, top-to-bottom. Overlapping COPY is not corrected.

Optional Feature:
- Macro VRAM_BLIT_COLORKEY_EN.
- Defined: in COPY, a read pixel equal to cmd_color is not written. GAP_R goes directly to advance (no WR transaction, no stb).
- Undefined: cmd_color is ignored for COPY; every pixel is written.
- FILL is unaffected either way.

Test Plan:
- FILL dst=0x80000, w=3, h=2, color=0x0808, pitch 640, responder acks on 2nd stb cycle -> writes to 0x80000-0x80002 and 0x80280-0x80282, v_dina=0x000000000808 each, ≥1 idle cycle between stbs, single done, no err, 18 cycles stb+gap.
- COPY src=0x80010, dst=0x80400, w=2, h=1, responder returns 0x1234, 0xABCD -> read/write alternation, writes 0x1234@0x80400 and 0xABCD@0x80401.
- Spurious ack: v_ACK=1 in first stb cycle only, then 0 for 3 cycles, then 1 -> transfer accepted only on final edge, v_addra/v_dina stable throughout.
- v_ACK held 0, TIMEOUT=255 -> v_stb drops after 255 stb cycles, done=err=1 same cycle, cmd_ready=1 next; w=0 command -> done one cycle after accept, v_stb never asserted.
- Wrap: FILL dst=0xFFFFF, w=2, h=1 -> writes 0xFFFFF then 0x00000. rst_n low during WR -> v_stb=0 immediately, busy=0, no done.
- VRAM_BLIT_COLORKEY_EN defined, COPY w=3, key 0x0000, source pixels 0x0001, 0x0000, 0x0002 -> only two write transactions (pixels 0 and 2).

Source files
------------

// File: rtl/vram_blit.sv
// vram_blit: rectangle FILL/COPY engine that is the sole master on the SRAM controller's VRAM port.
// Optional: define VRAM_BLIT_COLORKEY_EN to skip COPY writes of pixels equal to cmd_color.
module vram_blit #(
   parameter int ADDR_W    = 20,
   parameter int DIM_W     = 10,
   parameter int ROW_PITCH = 640,
   parameter int TIMEOUT   = 255
) (
   input  logic              clk_50mhz,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [DIM_W-1:0]  cmd_w,
   input  logic [DIM_W-1:0]  cmd_h,
   input  logic [15:0]       cmd_color,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              v_stb,
   output logic              v_we,
   output logic [ADDR_W-1:0] v_addra,
   output logic [47:0]       v_dina,
   input  logic [47:0]       v_douta,
   input  logic              v_ACK
);
   // state  | meaning
   // IDLE   | waiting for a command, cmd_ready=1
   // RD     | read transaction at src_ptr (v_stb high)
   // GAP_R  | v_stb low after read accept
   // WR     | write transaction at dst_ptr (v_stb high)
   // GAP_W  | v_stb low after write accept, pointers advance
   // DONE   | one-cycle done (and err on timeout) pulse
   typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP_R, S_WR, S_GAP_W, S_DONE} state_t;

   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t            state_q, state_d;
   logic              op_q, op_d;
   logic [15:0]       color_q, color_d;
   logic [DIM_W-1:0]  w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0] src_row_q, src_row_d, dst_row_q, dst_row_d;
   logic [ADDR_W-1:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
   logic [15:0]       pixel_q, pixel_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              v_stb_q, v_stb_d, v_we_q, v_we_d;
   logic [ADDR_W-1:0] v_addra_q, v_addra_d;
   logic [47:0]       v_dina_q, v_dina_d;
   logic              accept, timeout, do_adv;
   logic              unused_douta;

   assign unused_douta = ^v_douta[47:16];

   // The controller flags ready spuriously in the first strobe cycle, so cnt_q==0 masks v_ACK.
   assign accept  = v_stb_q && (cnt_q != '0) && v_ACK;
   assign timeout = v_stb_q && !accept && (cnt_q == TO_W'(TIMEOUT - 1));
   assign cnt_d   = (v_stb_q && !accept && !timeout) ? cnt_q + TO_W'(1) : '0;

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= 1'b0;
         color_q   <= '0;
         w_q       <= '0;
         h_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         src_row_q <= '0;
         dst_row_q <= '0;
         src_ptr_q <= '0;
         dst_ptr_q <= '0;
         pixel_q   <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         v_stb_q   <= 1'b0;
         v_we_q    <= 1'b0;
         v_addra_q <= '0;
         v_dina_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         color_q   <= color_d;
         w_q       <= w_d;
         h_q       <= h_d;
         x_q       <= x_d;
         y_q       <= y_d;
         src_row_q <= src_row_d;
         dst_row_q <= dst_row_d;
         src_ptr_q <= src_ptr_d;
         dst_ptr_q <= dst_ptr_d;
         pixel_q   <= pixel_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         v_stb_q   <= v_stb_d;
         v_we_q    <= v_we_d;
         v_addra_q <= v_addra_d;
         v_dina_q  <= v_dina_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      color_d   = color_q;
      w_d       = w_q;
      h_d       = h_q;
      x_d       = x_q;
      y_d       = y_q;
      src_row_d = src_row_q;
      dst_row_d = dst_row_q;
      src_ptr_d = src_ptr_q;
      dst_ptr_d = dst_ptr_q;
      pixel_d   = pixel_q;
      err_d     = err_q;
      do_adv    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d      = cmd_op;
               color_d   = cmd_color;
               w_d       = cmd_w;
               h_d       = cmd_h;
               x_d       = '0;
               y_d       = '0;
               src_row_d = cmd_src;
               src_ptr_d = cmd_src;
               dst_row_d = cmd_dst;
               dst_ptr_d = cmd_dst;
               err_d     = 1'b0;
               if (cmd_w == '0 || cmd_h == '0) state_d = S_DONE;
               else state_d = cmd_op ? S_RD : S_WR;
            end
         end
         S_RD: begin
            if (accept) begin
               pixel_d = v_douta[15:0];
               state_d = S_GAP_R;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_GAP_R: begin
`ifdef VRAM_BLIT_COLORKEY_EN
            if (pixel_q == color_q) do_adv = 1'b1;
            else state_d = S_WR;
`else
            state_d = S_WR;
`endif
         end
         S_WR: begin
            if (accept) begin
               state_d = S_GAP_W;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_GAP_W: do_adv = 1'b1;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (do_adv) begin
         if (x_q != w_q - DIM_W'(1)) begin
            x_d       = x_q + DIM_W'(1);
            src_ptr_d = src_ptr_q + ADDR_W'(1);
            dst_ptr_d = dst_ptr_q + ADDR_W'(1);
            state_d   = op_q ? S_RD : S_WR;
         end else if (y_q != h_q - DIM_W'(1)) begin
            x_d       = '0;
            y_d       = y_q + DIM_W'(1);
            src_row_d = src_row_q + ADDR_W'(ROW_PITCH);
            dst_row_d = dst_row_q + ADDR_W'(ROW_PITCH);
            src_ptr_d = src_row_d;
            dst_ptr_d = dst_row_d;
            state_d   = op_q ? S_RD : S_WR;
         end else begin
            state_d = S_DONE;
         end
      end
   end

   // Bus outputs are registered from the next state so they stay frozen while a transfer waits.
   always_comb begin
      v_stb_d   = (state_d == S_RD) || (state_d == S_WR);
      v_we_d    = (state_d == S_WR);
      v_addra_d = v_addra_q;
      v_dina_d  = v_dina_q;
      if (state_d == S_RD) begin
         v_addra_d = src_ptr_d;
      end else if (state_d == S_WR) begin
         v_addra_d = dst_ptr_d;
         v_dina_d  = {32'h0, (op_d ? pixel_d : color_d)};
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_DONE) && err_q;
   assign v_stb     = v_stb_q;
   assign v_we      = v_we_q;
   assign v_addra   = v_addra_q;
   assign v_dina    = v_dina_q;
endmodule
